// File: rtl/boot_sequencer_if.sv
// Boot sequencer bus bundle.
//   rx_valid/rx_data : byte stream from the UART receiver
//   tx_busy          : UART transmitter busy
//   tx_start/tx_data : one-cycle transmit request and its byte
//   addra/dina/wea   : instruction BRAM write port (word address)
//   mode             : global core mode (0=STALL, 1=LOAD, 2=EXEC)
//   load_err         : sticky header-error flag
// The master modport is the sequencer; the slave modport is the UART/BRAM/core side.
interface boot_sequencer_if #(
  parameter int unsigned INST_SIZE = 14
);
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 tx_busy;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic [INST_SIZE-1:0] addra;
  logic [31:0]          dina;
  logic                 wea;
  logic [2:0]           mode;
  logic                 load_err;

  modport master (
    input  rx_valid, rx_data, tx_busy,
    output tx_start, tx_data, addra, dina, wea, mode, load_err
  );

  modport slave (
    output rx_valid, rx_data, tx_busy,
    input  tx_start, tx_data, addra, dina, wea, mode, load_err
  );
endinterface

// File: rtl/boot_sequencer.sv
// Program-load sequencer. Packs the incoming UART byte stream (little-endian) into 32-bit
// words, writes them into the instruction BRAM, drives the core mode code and reports the
// load outcome to the host with a single ack or error byte.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : boot_sequencer_if master modport (UART rx/tx, BRAM write port, mode, load_err)
// Stream format: 4-byte word count nwords, then nwords 4-byte words.
module boot_sequencer #(
  parameter int unsigned INST_SIZE = 14,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA,
  parameter logic [7:0]  ERR_BYTE  = 8'h55
) (
  input logic             clk,
  input logic             rstn,
  boot_sequencer_if.master bus
);

  localparam logic [31:0] Capacity = 32'd1 << INST_SIZE;

  localparam logic [2:0] ModeStall = 3'd0;
  localparam logic [2:0] ModeLoad  = 3'd1;
  localparam logic [2:0] ModeExec  = 3'd2;

  typedef enum logic [2:0] {StHdr, StBody, StAck, StRun, StErr} state_e;

  state_e               state_q, state_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [23:0]          buf_q, buf_d;        // bytes 0..2 of the group in flight
  logic [31:0]          nwords_q, nwords_d;
  logic [INST_SIZE:0]   word_idx_q, word_idx_d;
  logic                 wea_q, wea_d;
  logic [INST_SIZE-1:0] addra_q, addra_d;
  logic [31:0]          dina_q, dina_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_done_q, tx_done_d;  // one response byte per reset
  logic                 load_err_q, load_err_d;
  logic [2:0]           mode_q, mode_d;

  logic                 take_byte;
  logic                 group_done;
  logic [31:0]          full_word;
  logic [31:0]          word_idx_ext;

  // Bytes only matter while the header or body is being received.
  assign take_byte    = bus.rx_valid && (state_q == StHdr || state_q == StBody);
  assign group_done   = take_byte && (byte_cnt_q == 2'd3);
  assign full_word    = {bus.rx_data, buf_q};
  assign word_idx_ext = 32'(word_idx_q);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    nwords_d   = nwords_q;
    word_idx_d = word_idx_q;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_done_d  = tx_done_q;
    load_err_d = load_err_q;
    mode_d     = mode_q;

    if (take_byte) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      unique case (byte_cnt_q)
        2'd0:    buf_d[7:0]   = bus.rx_data;
        2'd1:    buf_d[15:8]  = bus.rx_data;
        2'd2:    buf_d[23:16] = bus.rx_data;
        default: ;  // 4th byte is consumed directly via full_word
      endcase
    end

    unique case (state_q)
      StHdr: begin
        if (group_done) begin
          nwords_d = full_word;
          if (full_word == 32'd0 || full_word > Capacity) begin
            state_d    = StErr;
            load_err_d = 1'b1;
            tx_data_d  = ERR_BYTE;
          end else begin
            state_d = StBody;
          end
        end
      end
      StBody: begin
        if (group_done) begin
          wea_d      = 1'b1;
          addra_d    = word_idx_q[INST_SIZE-1:0];
          dina_d     = full_word;
          word_idx_d = word_idx_q + 1'b1;
          if (word_idx_ext == nwords_q - 32'd1) begin
            state_d   = StAck;
            tx_data_d = ACK_BYTE;
          end
        end
      end
      StAck: begin
        // Leave for RUN the cycle after the ack pulse is on the wire.
        if (tx_done_q) begin
          state_d = StRun;
        end else if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_done_d  = 1'b1;
        end
      end
      StErr: begin
        if (!tx_done_q && !bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_done_d  = 1'b1;
        end
      end
      StRun: ;
      default: state_d = StHdr;
    endcase

    unique case (state_d)
      StBody, StAck: mode_d = ModeLoad;
      StRun:         mode_d = ModeExec;
      default:       mode_d = ModeStall;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StHdr;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      nwords_q   <= '0;
      word_idx_q <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_done_q  <= 1'b0;
      load_err_q <= 1'b0;
      mode_q     <= ModeStall;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      nwords_q   <= nwords_d;
      word_idx_q <= word_idx_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      tx_done_q  <= tx_done_d;
      load_err_q <= load_err_d;
      mode_q     <= mode_d;
    end
  end

  assign bus.wea      = wea_q;
  assign bus.addra    = addra_q;
  assign bus.dina     = dina_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.load_err = load_err_q;
  assign bus.mode     = mode_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer, built with a small instruction memory (INST_SIZE=8)
// so the full-capacity load stays short.
module tb_boot_sequencer;

  localparam int unsigned INST = 8;

  logic clk;
  logic rstn;

  boot_sequencer_if #(.INST_SIZE(INST)) bus ();

  boot_sequencer #(
    .INST_SIZE(INST),
    .ACK_BYTE (8'hAA),
    .ERR_BYTE (8'h55)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [7:0]  txq[$];
  int          dbl_pulse = 0;
  bit          prev_wea = 1'b0;
  bit          prev_tx  = 1'b0;

  // Record every write and transmit pulse, and any pulse lasting two cycles.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.wea) begin
        wq_addr.push_back(32'(bus.addra));
        wq_data.push_back(bus.dina);
      end
      if (bus.tx_start) txq.push_back(bus.tx_data);
      if ((bus.wea && prev_wea) || (bus.tx_start && prev_tx)) dbl_pulse++;
    end
    prev_wea = bus.wea;
    prev_tx  = bus.tx_start;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; consecutive calls give back-to-back rx_valid.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    txq.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.tx_busy = 1'b0;
    #1;
    wait_cycles(2);
    clear_q();
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] pat_word(input int w);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4 * w);
    b1 = 8'(4 * w + 1);
    b2 = 8'(4 * w + 2);
    b3 = 8'(4 * w + 3);
    return {b3, b2, b1, b0};
  endfunction

  initial begin
    rstn         = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_busy  = 1'b0;
    #3;
    check("rst_mode", 32'(bus.mode), 32'd0);
    check("rst_wea", 32'(bus.wea), 32'd0);
    check("rst_addra", 32'(bus.addra), 32'd0);
    check("rst_dina", bus.dina, 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_load_err", 32'(bus.load_err), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Two-word load
    send_word(32'd2);
    check("t1_mode_body", 32'(bus.mode), 32'd1);
    send_word(32'h0403_0201);
    send_word(32'h0807_0605);
    wait_cycles(5);
    check("t1_nwrites", 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() == 2) begin
      check("t1_addr0", wq_addr[0], 32'd0);
      check("t1_data0", wq_data[0], 32'h0403_0201);
      check("t1_addr1", wq_addr[1], 32'd1);
      check("t1_data1", wq_data[1], 32'h0807_0605);
    end
    check("t1_ntx", 32'(txq.size()), 32'd1);
    if (txq.size() == 1) check("t1_tx_byte", 32'(txq[0]), 32'hAA);
    check("t1_mode_run", 32'(bus.mode), 32'd2);
    check("t1_load_err", 32'(bus.load_err), 32'd0);

    // Bytes in RUN are ignored
    clear_q();
    send_word(32'h1122_3344);
    send_word(32'h5566_7788);
    wait_cycles(4);
    check("t7_nwrites", 32'(wq_addr.size()), 32'd0);
    check("t7_ntx", 32'(txq.size()), 32'd0);
    check("t7_mode", 32'(bus.mode), 32'd2);

    // Zero word count
    do_reset();
    send_word(32'd0);
    wait_cycles(5);
    check("t2_load_err", 32'(bus.load_err), 32'd1);
    check("t2_ntx", 32'(txq.size()), 32'd1);
    if (txq.size() == 1) check("t2_tx_byte", 32'(txq[0]), 32'h55);
    check("t2_mode", 32'(bus.mode), 32'd0);
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    wait_cycles(5);
    check("t2_ntx_once", 32'(txq.size()), 32'd1);
    check("t2_nwrites", 32'(wq_addr.size()), 32'd0);
    check("t2_mode_hold", 32'(bus.mode), 32'd0);

    // One past capacity
    do_reset();
    send_word(32'd257);
    wait_cycles(5);
    check("t3_load_err", 32'(bus.load_err), 32'd1);
    check("t3_ntx", 32'(txq.size()), 32'd1);
    if (txq.size() == 1) check("t3_tx_byte", 32'(txq[0]), 32'h55);
    check("t3_mode", 32'(bus.mode), 32'd0);
    check("t3_nwrites", 32'(wq_addr.size()), 32'd0);

    // Oversize count only visible in the top byte
    do_reset();
    send_word(32'h0100_0001);
    wait_cycles(5);
    check("t3b_load_err", 32'(bus.load_err), 32'd1);
    check("t3b_mode", 32'(bus.mode), 32'd0);

    // Exactly full memory, back-to-back bytes
    do_reset();
    send_word(32'd256);
    for (int w = 0; w < 256; w++) send_word(pat_word(w));
    wait_cycles(5);
    check("t4_nwrites", 32'(wq_addr.size()), 32'd256);
    if (wq_addr.size() == 256) begin
      for (int w = 0; w < 256; w++) begin
        check("t4_addr", wq_addr[w], 32'(w));
        check("t4_data", wq_data[w], pat_word(w));
      end
      check("t4_last_addr", wq_addr[255], 32'hFF);
    end
    check("t4_ntx", 32'(txq.size()), 32'd1);
    if (txq.size() == 1) check("t4_tx_byte", 32'(txq[0]), 32'hAA);
    check("t4_mode", 32'(bus.mode), 32'd2);

    // Transmitter busy at ACK
    do_reset();
    bus.tx_busy = 1'b1;
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    wait_cycles(50);
    check("t5_ntx_busy", 32'(txq.size()), 32'd0);
    check("t5_mode_busy", 32'(bus.mode), 32'd1);
    check("t5_nwrites", 32'(wq_addr.size()), 32'd1);
    bus.tx_busy = 1'b0;
    wait_cycles(4);
    check("t5_ntx", 32'(txq.size()), 32'd1);
    if (txq.size() == 1) check("t5_tx_byte", 32'(txq[0]), 32'hAA);
    check("t5_mode_run", 32'(bus.mode), 32'd2);

    // Reset in the middle of the body
    do_reset();
    send_word(32'd5);
    send_word(32'h0000_0011);
    send_word(32'h0000_0022);
    send_word(32'h0000_0033);
    wait_cycles(2);
    check("t6_nwrites_pre", 32'(wq_addr.size()), 32'd3);
    rstn = 1'b0;
    #1;
    check("t6_rst_mode", 32'(bus.mode), 32'd0);
    check("t6_rst_addra", 32'(bus.addra), 32'd0);
    check("t6_rst_dina", bus.dina, 32'd0);
    wait_cycles(2);
    clear_q();
    rstn = 1'b1;
    send_word(32'd1);
    send_word(32'hAABB_CCDD);
    wait_cycles(5);
    check("t6_nwrites", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() == 1) begin
      check("t6_addr", wq_addr[0], 32'd0);
      check("t6_data", wq_data[0], 32'hAABB_CCDD);
    end
    check("t6_mode", 32'(bus.mode), 32'd2);

    check("dbl_pulse", 32'(dbl_pulse), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
